player_motion: RTL and testbench

Player movement controller that sits directly upstream of the `player` drawing stage. It owns the player's pixel position and turns button input into one-pixel moves, one move per `step` request. Moves are checked against the maze wall maps fed to `scene_exhibitor`. It produces `pos_x`/`pos_y` for the drawer and a cell-entered event with a cell index for food bookkeeping. The top level pulses `step` each time `player` finishes a frame and feeds `pos_x + 5`/`pos_y + 5` to `player`.

---
 rtl/player_motion_if.sv | 22 ++
 rtl/player_motion.sv | 155 +++++++++++++++
 tb/tb_player_motion.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/player_motion_if.sv
// Step handshake and position/status bus between the frame sequencer and the movement controller.
interface player_motion_if;
  logic       step;
  logic       busy;
  logic       done;
  logic       moved;
  logic       cell_entered;
  logic [8:0] pos_x;
  logic [8:0] pos_y;
  logic [1:0] dir;
  logic [7:0] cell_index;

  modport master (
    output step,
    input  busy, done, moved, cell_entered, pos_x, pos_y, dir, cell_index
  );

  modport slave (
    input  step,
    output busy, done, moved, cell_entered, pos_x, pos_y, dir, cell_index
  );
endinterface

// File: rtl/player_motion.sv
// Player movement controller: one-pixel moves per step, wall-checked at cell origins.
// Fixed 4-cycle update (IDLE->CHECK->MOVE->DONE); step outside IDLE is dropped, never queued.
module player_motion #(
  parameter int CELL_BITS = 5,
  parameter int COLS      = 10,
  parameter int ROWS      = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         button_1,
  input  logic                         button_2,
  input  logic [(ROWS+1)*COLS-1:0]     h_walls,
  input  logic [ROWS*(COLS+1)-1:0]     v_walls,
  player_motion_if.slave               bus
);

  localparam int CW  = 9 - CELL_BITS;
  localparam int HW  = (ROWS + 1) * COLS;
  localparam int VW  = ROWS * (COLS + 1);
  localparam int HIW = $clog2(HW);
  localparam int VIW = $clog2(VW);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_MOVE, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [8:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [1:0] dir_q, dir_d;
  logic [7:0] cell_index_q, cell_index_d;
  logic       aligned_q, aligned_d;
  logic       blocked_q, blocked_d;
  logic       moved_q, moved_d;
  logic [1:0] btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;

  logic [CW-1:0]  cx, cy;
  logic [HIW-1:0] h_idx;
  logic [VIW-1:0] v_idx;
  logic           edge_hit, wall_hit;
  logic [7:0]     nx8, ny8;

  assign cx = pos_x_q[8:CELL_BITS];
  assign cy = pos_y_q[8:CELL_BITS];

  // Wall lookup for the latched direction; maps are stored MSB-first.
  always_comb begin
    h_idx    = '0;
    v_idx    = '0;
    edge_hit = 1'b0;
    wall_hit = 1'b0;
    case (dir_q)
      2'd0: begin
        edge_hit = (cx == CW'(COLS - 1));
        v_idx    = VIW'(VW - 1) - (VIW'(cy) * VIW'(COLS + 1) + VIW'(cx) + VIW'(1));
        wall_hit = v_walls[v_idx];
      end
      2'd1: begin
        edge_hit = (cy == CW'(ROWS - 1));
        h_idx    = HIW'(HW - 1) - ((HIW'(cy) + HIW'(1)) * HIW'(COLS) + HIW'(cx));
        wall_hit = h_walls[h_idx];
      end
      2'd2: begin
        edge_hit = (cx == '0);
        v_idx    = VIW'(VW - 1) - (VIW'(cy) * VIW'(COLS + 1) + VIW'(cx));
        wall_hit = v_walls[v_idx];
      end
      default: begin
        edge_hit = (cy == '0);
        h_idx    = HIW'(HW - 1) - (HIW'(cy) * HIW'(COLS) + HIW'(cx));
        wall_hit = h_walls[h_idx];
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    dir_d        = dir_q;
    cell_index_d = cell_index_q;
    aligned_d    = aligned_q;
    blocked_d    = blocked_q;
    moved_d      = moved_q;
    btn_meta_d   = {button_1, button_2};
    btn_sync_d   = btn_meta_q;
    nx8          = '0;
    ny8          = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.step) begin
          aligned_d = (pos_x_q[CELL_BITS-1:0] == '0) && (pos_y_q[CELL_BITS-1:0] == '0);
          if (aligned_d) dir_d = btn_sync_q;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // Mid-cell moves always run to the next origin, so walls only matter when aligned.
        blocked_d = aligned_q & (edge_hit | wall_hit);
        state_d   = S_MOVE;
      end
      S_MOVE: begin
        moved_d = ~blocked_q;
        if (!blocked_q) begin
          case (dir_q)
            2'd0:    pos_x_d = pos_x_q + 9'd1;
            2'd1:    pos_y_d = pos_y_q + 9'd1;
            2'd2:    pos_x_d = pos_x_q - 9'd1;
            default: pos_y_d = pos_y_q - 9'd1;
          endcase
        end
        nx8          = 8'(pos_x_d[8:CELL_BITS]);
        ny8          = 8'(pos_y_d[8:CELL_BITS]);
        cell_index_d = (ny8 << 3) + (ny8 << 1) + nx8;
        state_d      = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      dir_q        <= '0;
      cell_index_q <= '0;
      aligned_q    <= 1'b0;
      blocked_q    <= 1'b0;
      moved_q      <= 1'b0;
      btn_meta_q   <= '0;
      btn_sync_q   <= '0;
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      dir_q        <= dir_d;
      cell_index_q <= cell_index_d;
      aligned_q    <= aligned_d;
      blocked_q    <= blocked_d;
      moved_q      <= moved_d;
      btn_meta_q   <= btn_meta_d;
      btn_sync_q   <= btn_sync_d;
    end
  end

  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.moved        = (state_q == S_DONE) & moved_q;
  assign bus.cell_entered = (state_q == S_DONE) & moved_q &
                            (pos_x_q[CELL_BITS-1:0] == '0) & (pos_y_q[CELL_BITS-1:0] == '0);
  assign bus.pos_x        = pos_x_q;
  assign bus.pos_y        = pos_y_q;
  assign bus.dir          = dir_q;
  assign bus.cell_index   = cell_index_q;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: timing, cell crossing, wall/edge blocking, direction latching, abort.
module tb_player_motion;
  logic         clk;
  logic         rst;
  logic         button_1, button_2;
  logic [159:0] h_walls;
  logic [164:0] v_walls;
  int           checks;
  int           errors;

  player_motion_if bus ();

  player_motion dut (
    .clk      (clk),
    .rst      (rst),
    .button_1 (button_1),
    .button_2 (button_2),
    .h_walls  (h_walls),
    .v_walls  (v_walls),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(2);
    rst = 1'b1;
  endtask

  // Pulses step once and waits (bounded) for done; returns with the FSM back in IDLE.
  task automatic run_step(output bit got, output bit mv, output bit ce);
    got = 1'b0; mv = 1'b0; ce = 1'b0;
    @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (bus.done) begin
        got = 1'b1;
        mv  = bus.moved;
        ce  = bus.cell_entered;
      end else begin
        @(negedge clk);
      end
    end
    if (got) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wait_cycles(2);
    checks++; if (bus.pos_x !== 9'd0) begin errors++; $display("FAIL reset_pos_x: got %0d expected 0", bus.pos_x); end
    checks++; if (bus.pos_y !== 9'd0) begin errors++; $display("FAIL reset_pos_y: got %0d expected 0", bus.pos_y); end
    checks++; if (bus.dir !== 2'd0) begin errors++; $display("FAIL reset_dir: got %0d expected 0", bus.dir); end
    checks++; if (bus.cell_index !== 8'd0) begin errors++; $display("FAIL reset_cell_index: got %0d expected 0", bus.cell_index); end
    checks++; if ({bus.busy, bus.done, bus.moved, bus.cell_entered} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got busy/done/moved/entered=%b expected 0000",
                         {bus.busy, bus.done, bus.moved, bus.cell_entered});
    end
    rst = 1'b1;
  endtask

  task automatic test_single_step();
    @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    checks++; if ({bus.busy, bus.done} !== 2'b10) begin errors++; $display("FAIL step_n1: got busy/done=%b expected 10", {bus.busy, bus.done}); end
    @(negedge clk);
    checks++; if ({bus.busy, bus.done} !== 2'b10) begin errors++; $display("FAIL step_n2: got busy/done=%b expected 10", {bus.busy, bus.done}); end
    checks++; if (bus.pos_x !== 9'd0) begin errors++; $display("FAIL step_n2_pos_x: got %0d expected 0", bus.pos_x); end
    @(negedge clk);
    checks++; if ({bus.busy, bus.done, bus.moved, bus.cell_entered} !== 4'b1110) begin
      errors++; $display("FAIL step_n3_flags: got busy/done/moved/entered=%b expected 1110",
                         {bus.busy, bus.done, bus.moved, bus.cell_entered});
    end
    checks++; if (bus.pos_x !== 9'd1 || bus.pos_y !== 9'd0) begin
      errors++; $display("FAIL step_n3_pos: got (%0d,%0d) expected (1,0)", bus.pos_x, bus.pos_y);
    end
    checks++; if (bus.dir !== 2'd0) begin errors++; $display("FAIL step_dir: got %0d expected 0", bus.dir); end
    @(negedge clk);
    checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL step_n4: got busy/done=%b expected 00", {bus.busy, bus.done}); end
  endtask

  // Continues from x=1; a wall on line 1 must not stop a move already inside cell 0.
  task automatic test_cell_cross();
    bit got, mv, ce;
    int n_done, n_moved, n_ce;
    bit last_ce;
    n_done = 0; n_moved = 0; n_ce = 0; last_ce = 1'b0;
    v_walls[163] = 1'b1;
    for (int i = 0; i < 31; i++) begin
      run_step(got, mv, ce);
      n_done += int'(got); n_moved += int'(mv); n_ce += int'(ce);
      last_ce = ce;
    end
    v_walls = '0;
    checks++; if (n_done !== 31 || n_moved !== 31) begin errors++; $display("FAIL cross_counts: got done=%0d moved=%0d expected 31/31", n_done, n_moved); end
    checks++; if (n_ce !== 1 || last_ce !== 1'b1) begin errors++; $display("FAIL cross_entered: got count=%0d last=%0d expected 1/1", n_ce, last_ce); end
    checks++; if (bus.pos_x !== 9'd32 || bus.pos_y !== 9'd0) begin errors++; $display("FAIL cross_pos: got (%0d,%0d) expected (32,0)", bus.pos_x, bus.pos_y); end
    checks++; if (bus.cell_index !== 8'd1) begin errors++; $display("FAIL cross_cell_index: got %0d expected 1", bus.cell_index); end
  endtask

  task automatic test_wall_block();
    bit got, mv, ce;
    do_reset();
    v_walls[163] = 1'b1;
    run_step(got, mv, ce);
    v_walls = '0;
    checks++; if (got !== 1'b1 || mv !== 1'b0) begin errors++; $display("FAIL vwall_block: got done=%0d moved=%0d expected 1/0", got, mv); end
    checks++; if (bus.pos_x !== 9'd0 || bus.pos_y !== 9'd0) begin errors++; $display("FAIL vwall_pos: got (%0d,%0d) expected (0,0)", bus.pos_x, bus.pos_y); end
    button_1 = 1'b0; button_2 = 1'b1;
    wait_cycles(3);
    h_walls[149] = 1'b1;
    run_step(got, mv, ce);
    h_walls = '0;
    checks++; if (got !== 1'b1 || mv !== 1'b0 || bus.dir !== 2'd1) begin
      errors++; $display("FAIL hwall_block: got done=%0d moved=%0d dir=%0d expected 1/0/1", got, mv, bus.dir);
    end
    run_step(got, mv, ce);
    checks++; if (mv !== 1'b1 || bus.pos_y !== 9'd1 || bus.pos_x !== 9'd0 || bus.cell_index !== 8'd0) begin
      errors++; $display("FAIL hwall_clear: got moved=%0d pos=(%0d,%0d) idx=%0d expected 1 (0,1) 0", mv, bus.pos_x, bus.pos_y, bus.cell_index);
    end
  endtask

  task automatic test_dir_latch();
    bit got, mv, ce;
    int n_moved;
    n_moved = 0;
    button_1 = 1'b0; button_2 = 1'b0;
    do_reset();
    wait_cycles(3);
    run_step(got, mv, ce);
    button_1 = 1'b1; button_2 = 1'b1;
    wait_cycles(3);
    for (int i = 0; i < 31; i++) begin
      run_step(got, mv, ce);
      n_moved += int'(mv);
    end
    checks++; if (n_moved !== 31 || bus.pos_x !== 9'd32 || bus.pos_y !== 9'd0 || bus.dir !== 2'd0) begin
      errors++; $display("FAIL latch_midcell: got moved=%0d pos=(%0d,%0d) dir=%0d expected 31 (32,0) 0", n_moved, bus.pos_x, bus.pos_y, bus.dir);
    end
    run_step(got, mv, ce);
    checks++; if (got !== 1'b1 || mv !== 1'b0 || bus.dir !== 2'd3) begin
      errors++; $display("FAIL latch_top_edge: got done=%0d moved=%0d dir=%0d expected 1/0/3", got, mv, bus.dir);
    end
    checks++; if (bus.pos_x !== 9'd32 || bus.pos_y !== 9'd0 || bus.cell_index !== 8'd1) begin
      errors++; $display("FAIL latch_pos: got (%0d,%0d) idx=%0d expected (32,0) 1", bus.pos_x, bus.pos_y, bus.cell_index);
    end
  endtask

  task automatic test_back_to_back();
    int n_done;
    button_1 = 1'b0; button_2 = 1'b0;
    do_reset();
    n_done = 0;
    @(negedge clk);
    bus.step = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) bus.step = 1'b0;
      if (bus.done) n_done++;
    end
    checks++; if (n_done !== 1 || bus.pos_x !== 9'd1) begin errors++; $display("FAIL b2b_ignored: got done=%0d pos_x=%0d expected 1/1", n_done, bus.pos_x); end

    n_done = 0;
    @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    if (bus.done) n_done++;
    @(negedge clk);
    if (bus.done) n_done++;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if ({bus.busy, bus.done} !== 2'b00 || bus.pos_x !== 9'd0) begin
      errors++; $display("FAIL abort_state: got busy/done=%b pos_x=%0d expected 00/0", {bus.busy, bus.done}, bus.pos_x);
    end
    for (int i = 0; i < 6; i++) begin
      if (bus.done) n_done++;
      @(negedge clk);
    end
    checks++; if (n_done !== 0 || bus.pos_x !== 9'd0) begin errors++; $display("FAIL abort_no_done: got done=%0d pos_x=%0d expected 0/0", n_done, bus.pos_x); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    bus.step = 1'b0;
    button_1 = 1'b0;
    button_2 = 1'b0;
    h_walls  = '0;
    v_walls  = '0;
    test_reset();
    wait_cycles(3);
    test_single_step();
    test_cell_cross();
    test_wall_block();
    test_dir_latch();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
